// File: rtl/orbit_group_dist_pkg.sv
// Shared defaults and reader state encoding for the orbit group distributor.
package orbit_group_dist_pkg;
  localparam int WORDS_DEF = 1024;
  localparam int DW_DEF    = 12;
  localparam int AW_DEF    = 10;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;
endpackage

// File: rtl/orbit_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; registered read with enable.
module orbit_bank_ram #(
  parameter int DW = 12,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  // Sized from the address width so the bank bit as MSB always indexes in range.
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/orbit_group_dist.sv
// Ping-pong frame buffer between the orbit packer and the LCB serializer.
// Handshake: a word transfers on any rising edge where oValid && iReady are both high;
// oWord/oValid stay stable until that transfer. Packer writes are accepted only while oBusy is low.
module orbit_group_dist
  import orbit_group_dist_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] iData,
  input  logic [AW-1:0] iAddr,
  input  logic          iWren,
  output logic          oBusy,
  output logic [DW-1:0] oWord,
  output logic          oValid,
  input  logic          iReady,
  output logic          oFrameStart,
  output logic          oOvf,
  output rd_state_t     dbg_state
);
  localparam logic [AW:0]   WORDS_X = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LAST    = AW'(WORDS - 1);

  // Assert asynchronously, release synchronously.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic wb_full, rb_full, bank_sel, ovf;
  logic wr_ok, commit, swap, xfer, last_xfer;

  rd_state_t     state, state_nx;
  logic [AW-1:0] ptr, ptr_nx, rd_addr;
  logic          rd_en;
  logic [DW-1:0] rdata;

  assign wr_ok     = iWren && !wb_full && ({1'b0, iAddr} < WORDS_X);
  assign commit    = wr_ok && (iAddr == LAST);
  assign swap      = wb_full && !rb_full;
  assign xfer      = (state == RD_STREAM) && iReady;
  assign last_xfer = xfer && (ptr == LAST);

  // swap needs rb_full low while last_xfer needs it high, so the branches never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_full  <= 1'b0;
      rb_full  <= 1'b0;
      bank_sel <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (iWren && wb_full) ovf <= 1'b1;
      if (swap) begin
        bank_sel <= ~bank_sel;
        wb_full  <= 1'b0;
        rb_full  <= 1'b1;
      end else begin
        if (commit)    wb_full <= 1'b1;
        if (last_xfer) rb_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RD_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // The RAM read is issued only when the presented word changes, so rdata doubles as the hold register.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    rd_en    = 1'b0;
    rd_addr  = ptr;
    case (state)
      RD_IDLE: begin
        ptr_nx = '0;
        if (rb_full || swap) state_nx = RD_FETCH;
      end
      RD_FETCH: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        ptr_nx   = '0;
        state_nx = RD_STREAM;
      end
      RD_STREAM: begin
        if (xfer) begin
          if (ptr == LAST) begin
            state_nx = RD_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = ptr + 1'b1;
            ptr_nx  = ptr + 1'b1;
          end
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  orbit_bank_ram #(.DW(DW), .AW(AW + 1)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({bank_sel, iAddr}),
    .wdata (iData),
    .re    (rd_en),
    .raddr ({~bank_sel, rd_addr}),
    .rdata (rdata)
  );

  assign oBusy       = wb_full;
  assign oValid      = (state == RD_STREAM);
  assign oWord       = oValid ? rdata : '0;
  assign oFrameStart = oValid && (ptr == '0);
  assign oOvf        = ovf;
  assign dbg_state   = state;
endmodule

// File: tb/tb_orbit_group_dist.sv
// Directed bench for orbit_group_dist: frames written by the bench, streamed words checked in order.
module tb_orbit_group_dist;
  import orbit_group_dist_pkg::*;

  localparam int WORDS = 1024;
  localparam int DW    = 12;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] iData = '0;
  logic [AW-1:0] iAddr = '0;
  logic          iWren = 1'b0;
  logic          iReady = 1'b0;
  logic          oBusy, oValid, oFrameStart, oOvf;
  logic [DW-1:0] oWord;
  rd_state_t     dbg_state;

  orbit_group_dist #(.WORDS(WORDS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .iData(iData), .iAddr(iAddr), .iWren(iWren),
    .oBusy(oBusy), .oWord(oWord), .oValid(oValid), .iReady(iReady),
    .oFrameStart(oFrameStart), .oOvf(oOvf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {frame_start, word}
  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];

  int          stab_err = 0;
  int          gap_cnt  = 0;
  int          gap_max  = 0;
  bit          gap_arm  = 0;
  int          busy_run = 0;
  int          busy_max = 0;
  logic        prev_hold = 1'b0;
  logic [DW-1:0] prev_word = '0;

  // Monitor: sampled on the falling edge, a transfer completes at the following rising edge.
  always @(negedge clk) begin
    if (prev_hold && oValid && (oWord !== prev_word)) stab_err++;
    prev_hold = oValid && !iReady;
    prev_word = oWord;
    if (oValid && iReady) begin
      got_q.push_back({oFrameStart, oWord});
      if (gap_arm && gap_cnt > gap_max) gap_max = gap_cnt;
      gap_cnt = 0;
      gap_arm = 1;
    end else begin
      gap_cnt++;
    end
    busy_run = oBusy ? busy_run + 1 : 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int seed, input int a);
    logic [31:0] v;
    v = a ^ seed;
    return v[DW-1:0];
  endfunction

  task automatic write_word(input int a, input logic [DW-1:0] d);
    int w = 0;
    while (oBusy && w < 20000) begin
      tick();
      w++;
    end
    if (oBusy) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_wait: addr=%0d oBusy still 1 after %0d cycles, required 0", a, w);
    end
    iWren = 1'b1;
    iAddr = AW'(a);
    iData = d;
    tick();
    iWren = 1'b0;
  endtask

  task automatic push_frame(input int seed);
    for (int a = 0; a < WORDS; a++) exp_q.push_back({a == 0, pat(seed, a)});
  endtask

  // interleave: even addresses then odd ones; the commit address always goes last.
  task automatic write_frame(input int seed, input bit interleave, input bit with_last);
    int a;
    for (int i = 0; i < WORDS - 1; i++) begin
      if (!interleave)        a = i;
      else if (i < WORDS / 2) a = 2 * i;
      else                    a = 2 * (i - WORDS / 2) + 1;
      write_word(a, pat(seed, a));
    end
    if (with_last) write_word(WORDS - 1, pat(seed, WORDS - 1));
  endtask

  task automatic collect(input int n, output bit ok);
    int w = 0;
    while (got_q.size() < n && w < 10000) begin
      tick();
      w++;
    end
    ok = (got_q.size() >= n);
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    iReady = 1'b0;
    repeat (3) tick();
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", oBusy); end
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", oValid); end
    n_checks++; if (oFrameStart !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b want 0", oFrameStart); end
    n_checks++; if (oWord !== '0) begin n_fail++; $display("FAIL rst_word: got %h want 000", oWord); end
    n_checks++; if (oOvf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", oOvf); end
    n_checks++; if (dbg_state !== RD_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, RD_IDLE); end
    reset = 1'b1;
    repeat (4) tick();
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL rel_valid: got %b want 0", oValid); end
  endtask

  task automatic test_single_frame();
    bit ok;
    iReady = 1'b1;
    push_frame(0);
    write_frame(0, 1'b0, 1'b1);
    n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1 after commit", oBusy); end
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_out_of_order();
    bit ok;
    iReady = 1'b1;
    push_frame(12'h2A5);
    write_frame(12'h2A5, 1'b1, 1'b1);
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ooo_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ooo_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    iReady  = 1'b1;
    gap_arm = 0; gap_max = 0; busy_max = 0;
    push_frame(12'h111);
    push_frame(12'h222);
    write_frame(12'h111, 1'b0, 1'b1);
    write_frame(12'h222, 1'b0, 1'b1);
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    n_checks++; if (gap_max > 3) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles want <= 3", gap_max); end
    n_checks++; if (busy_max < 2) begin n_fail++; $display("FAIL b2b_busy: got %0d busy cycles want >= 2", busy_max); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_coincide();
    bit ok;
    int w = 0;
    iReady = 1'b1;
    push_frame(12'h333);
    push_frame(12'h444);
    write_frame(12'h333, 1'b0, 1'b1);
    write_frame(12'h444, 1'b0, 1'b0);
    while (!(oValid && oWord === pat(12'h333, WORDS - 1)) && w < 5000) begin
      tick();
      w++;
    end
    n_checks++; if (!(oValid && iReady && !oBusy)) begin n_fail++; $display("FAIL coin_align: valid=%b busy=%b want last word presented with oBusy 0", oValid, oBusy); end
    write_word(WORDS - 1, pat(12'h444, WORDS - 1));
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL coin_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL coin_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_ready_toggle();
    bit ok;
    stab_err = 0;
    push_frame(12'h555);
    fork
      write_frame(12'h555, 1'b0, 1'b1);
      begin
        int w = 0;
        while (got_q.size() < WORDS && w < 8000) begin
          iReady = ~iReady;
          tick();
          w++;
        end
        iReady = 1'b1;
      end
    join
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tog_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tog_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL tog_stable: got %0d word changes while stalled want 0", stab_err); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    iReady = 1'b0;
    n_checks++; if (oOvf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", oOvf); end
    push_frame(12'h600);
    push_frame(12'h0A5);
    write_frame(12'h600, 1'b0, 1'b1);
    write_frame(12'h0A5, 1'b0, 1'b1);
    repeat (3) tick();
    n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b want 1 with both banks full", oBusy); end
    iWren = 1'b1; iAddr = AW'(5); iData = 12'h5A5;
    tick();
    iWren = 1'b0;
    tick();
    n_checks++; if (oOvf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", oOvf); end
    iReady = 1'b1;
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    n_checks++; if (oOvf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", oOvf); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    iReady = 1'b1;
    write_frame(12'h777, 1'b0, 1'b1);
    collect(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_reach: got %0d words want >= 500", got_q.size()); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", oValid); end
    n_checks++; if (oWord !== '0) begin n_fail++; $display("FAIL rmid_word: got %h want 000", oWord); end
    n_checks++; if (oFrameStart !== 1'b0) begin n_fail++; $display("FAIL rmid_fs: got %b want 0", oFrameStart); end
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", oBusy); end
    n_checks++; if (oOvf !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b want 0", oOvf); end
    repeat (3) tick();
    got_q.delete(); exp_q.delete();
    reset = 1'b1;
    repeat (4) tick();
    push_frame(12'h0F0);
    write_frame(12'h0F0, 1'b0, 1'b1);
    collect(exp_q.size(), ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rmid_word[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_out_of_order();
    test_back_to_back();
    test_coincide();
    test_ready_toggle();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
